// File: rtl/flash_cache_pkg.sv
// Shared definitions for the flash cache: controller states, bus widths,
// address field width helpers and the idle read-data value.
package flash_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_FILL    = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 32;
    localparam int BYTE_OFF_W = 2;

    localparam logic [DATA_W-1:0] IDLE_DATA = 32'hFFFF_FFFF;

    // Word offset within a line.
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line index.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Everything above the index is tag.
    function automatic int tag_w(input int line_words, input int lines);
        return ADDR_W - BYTE_OFF_W - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/flash_cache_line_store.sv
// Tag, valid and data storage for the direct-mapped cache.
// Data and tags are plain arrays with a registered read (RAM friendly);
// valid bits are flops so they can be reset and cleared in one cycle.
module flash_cache_line_store
    import flash_cache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 32,
    parameter int OFF_W      = 2,
    parameter int IDX_W      = 5,
    parameter int TAG_W      = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // read port (registered)
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic [DATA_W-1:0] rd_word_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    // valid lookup (combinational)
    input  logic [IDX_W-1:0]  vld_idx_i,
    output logic              vld_o,
    // write port
    input  logic              word_we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [DATA_W-1:0] wr_word_i,
    input  logic              tag_we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_valid_i,
    input  logic              clr_valid_i
);

    logic [DATA_W-1:0] data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] rd_word_q;
    logic [TAG_W-1:0]  rd_tag_q;
    logic [LINES-1:0]  valid_q;

    // Line data: one word written per fill beat, registered read.
    always_ff @(posedge clk_i) begin
        if (word_we_i) begin
            data_mem[{wr_idx_i, wr_off_i}] <= wr_word_i;
        end
        if (rd_en_i) begin
            rd_word_q <= data_mem[{rd_idx_i, rd_off_i}];
        end
    end

    // Tags: written once when a fill completes, registered read.
    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_mem[wr_idx_i] <= wr_tag_i;
        end
        if (rd_en_i) begin
            rd_tag_q <= tag_mem[rd_idx_i];
        end
    end

    // Valid bits: a global clear beats a simultaneous set.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                valid_q[gi] <= 1'b0;
            end else if (clr_valid_i) begin
                valid_q[gi] <= 1'b0;
            end else if (tag_we_i && wr_valid_i && (wr_idx_i == IDX_W'(gi))) begin
                valid_q[gi] <= 1'b1;
            end
        end
    end

    assign rd_word_o = rd_word_q;
    assign rd_tag_o  = rd_tag_q;
    assign vld_o     = valid_q[vld_idx_i];

endmodule

// File: rtl/flash_cache.sv
// Read-only direct-mapped cache between the Wishbone flash bridge and the
// QSPI flash controller. Hits answer in two cycles; misses fetch a whole
// line through the line-fill port and answer once the last word lands.
module flash_cache
    import flash_cache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        flashCache_readEnable,
    input  logic [23:0] flashCache_address,
    input  logic [3:0]  flashCache_byteSelect,
    output logic [31:0] flashCache_dataRead,
    output logic        flashCache_busy,
    input  logic        cache_invalidate,
    output logic        flash_request,
    output logic [23:0] flash_address,
    input  logic        flash_wordValid,
    input  logic [31:0] flash_dataRead
);

    localparam int OFF_W   = off_w(LINE_WORDS);
    localparam int IDX_W   = idx_w(LINES);
    localparam int TAG_W   = tag_w(LINE_WORDS, LINES);
    localparam int IDX_LSB = BYTE_OFF_W + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    state_e            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       resp_q, resp_d;
    logic              inv_seen_q, inv_seen_d;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              rd_en;
    logic [31:0]       st_word;
    logic [TAG_W-1:0]  st_tag;
    logic              st_valid;
    logic              word_we;
    logic              tag_we;
    logic              wr_valid;
    logic              unused_ok;

    assign req_off = addr_q[IDX_LSB-1:BYTE_OFF_W];
    assign req_idx = addr_q[TAG_LSB-1:IDX_LSB];
    assign req_tag = addr_q[23:TAG_LSB];

    // The storage read is launched with the incoming address on the same
    // edge that latches it, so tag and word are ready during LOOKUP.
    assign rd_en = (state_q == ST_IDLE) && flashCache_readEnable;

    assign unused_ok = &{1'b0, flashCache_byteSelect, addr_q[1:0]};

    flash_cache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES),
        .OFF_W      (OFF_W),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk_i       (wb_clk_i),
        .rst_n_i     (wb_rst_n_i),
        .rd_en_i     (rd_en),
        .rd_idx_i    (flashCache_address[TAG_LSB-1:IDX_LSB]),
        .rd_off_i    (flashCache_address[IDX_LSB-1:BYTE_OFF_W]),
        .rd_word_o   (st_word),
        .rd_tag_o    (st_tag),
        .vld_idx_i   (req_idx),
        .vld_o       (st_valid),
        .word_we_i   (word_we),
        .wr_idx_i    (req_idx),
        .wr_off_i    (cnt_q),
        .wr_word_i   (flash_dataRead),
        .tag_we_i    (tag_we),
        .wr_tag_i    (req_tag),
        .wr_valid_i  (wr_valid),
        .clr_valid_i (cache_invalidate)
    );

    // Controller state and datapath registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            resp_q     <= IDLE_DATA;
            inv_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            inv_seen_q <= inv_seen_d;
        end
    end

    // Next-state logic, storage write strobes and interface outputs.
    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        cnt_d               = cnt_q;
        resp_d              = resp_q;
        inv_seen_d          = inv_seen_q;
        word_we             = 1'b0;
        tag_we              = 1'b0;
        wr_valid            = 1'b0;
        flashCache_busy     = 1'b1;
        flashCache_dataRead = IDLE_DATA;
        flash_request       = 1'b0;
        flash_address       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (flashCache_readEnable) begin
                    addr_d  = flashCache_address;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (st_valid && (st_tag == req_tag)) begin
                    resp_d  = st_word;
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d      = '0;
                    inv_seen_d = 1'b0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                flash_request = 1'b1;
                flash_address = {addr_q[23:IDX_LSB], {IDX_LSB{1'b0}}};
                // An invalidate at any point in the fill, including the
                // final beat, leaves the freshly filled line invalid.
                inv_seen_d    = inv_seen_q | cache_invalidate;
                if (flash_wordValid) begin
                    word_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (cnt_q == req_off) begin
                        resp_d = flash_dataRead;
                    end
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        tag_we   = 1'b1;
                        wr_valid = !(inv_seen_q || cache_invalidate);
                        state_d  = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                flashCache_busy     = 1'b0;
                flashCache_dataRead = resp_q;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_flash_cache.sv
// Directed bench for flash_cache: a line-level cache model predicts, per
// cycle, busy / read data / fill request / fill address, and one compare
// process checks the DUT against it on every falling edge.
module tb_flash_cache;

    localparam int LW = 4;
    localparam int NL = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic [23:0] addr = '0;
    logic [3:0]  bsel = 4'hF;
    logic [31:0] rdata;
    logic        busy;
    logic        inv = 1'b0;
    logic        freq;
    logic [23:0] faddr;
    logic        wv = 1'b0;
    logic [31:0] fdata = '0;

    always #5 clk = ~clk;

    flash_cache #(.LINE_WORDS(LW), .LINES(NL)) dut (
        .wb_clk_i              (clk),
        .wb_rst_n_i            (rst_n),
        .flashCache_readEnable (re),
        .flashCache_address    (addr),
        .flashCache_byteSelect (bsel),
        .flashCache_dataRead   (rdata),
        .flashCache_busy       (busy),
        .cache_invalidate      (inv),
        .flash_request         (freq),
        .flash_address         (faddr),
        .flash_wordValid       (wv),
        .flash_dataRead        (fdata)
    );

    // Cache model: which memory line each slot holds and what it contains.
    bit          m_valid [NL];
    logic [14:0] m_tag   [NL];
    logic [31:0] m_data  [NL][LW];

    // Expected DUT outputs for the current cycle.
    logic        exp_busy  = 1'b1;
    logic [31:0] exp_data  = 32'hFFFF_FFFF;
    logic        exp_req   = 1'b0;
    logic [23:0] exp_faddr = '0;

    int total = 0;
    int bad   = 0;
    logic [31:0] got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("dataRead", rdata, exp_data);
        chk("flash_request", {31'd0, freq}, {31'd0, exp_req});
        chk("flash_address", {8'd0, faddr}, {8'd0, exp_faddr});
    end

    task automatic idle_exp();
        exp_busy  = 1'b1;
        exp_data  = 32'hFFFF_FFFF;
        exp_req   = 1'b0;
        exp_faddr = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read transaction starting in an idle cycle. On a miss the line is
    // supplied as base+0..base+LW-1 with 'gap' idle beats before each word.
    // inv_word >= 0 pulses invalidate alongside that fill word; inv_start
    // pulses it together with the request.
    task automatic do_read(input logic [23:0] a, input logic [31:0] base, input int gap,
                           input int inv_word, input bit inv_start, output logic [31:0] res);
        int  idx;
        int  off;
        bit  hit;
        bit  invd;
        idx  = int'(a[8:4]);
        off  = int'(a[3:2]);
        invd = 1'b0;
        addr = a;
        re   = 1'b1;
        if (inv_start) begin
            inv = 1'b1;
            clear_model();
        end
        hit = m_valid[idx] && (m_tag[idx] == a[23:9]);
        idle_exp();
        tick();                      // now LOOKUP
        inv  = 1'b0;
        addr = ~a;                   // must be ignored after the latch
        tick();                      // RESPOND on hit, FILL on miss
        if (!hit) begin
            exp_req   = 1'b1;
            exp_faddr = {a[23:4], 4'h0};
            for (int w = 0; w < LW; w++) begin
                repeat (gap) tick();
                wv    = 1'b1;
                fdata = base + 32'(w);
                m_data[idx][w] = fdata;
                if (w == inv_word) begin
                    inv  = 1'b1;
                    invd = 1'b1;
                    clear_model();
                end
                tick();
                wv  = 1'b0;
                inv = 1'b0;
            end
            m_tag[idx]   = a[23:9];
            m_valid[idx] = !invd;
        end
        exp_req   = 1'b0;
        exp_faddr = '0;
        exp_busy  = 1'b0;
        exp_data  = m_data[idx][off];
        @(negedge clk);
        res = rdata;
        tick();                      // back in IDLE
        re = 1'b0;
        idle_exp();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Cold miss, then hits on the same line.
        do_read(24'h000104, 32'hA0, 0, -1, 1'b0, got);
        chk("cold_miss_data", got, 32'hA1);
        do_read(24'h00010C, 32'h0, 0, -1, 1'b0, got);
        chk("hit_data", got, 32'hA3);

        // Stray fill beat while idle must not touch storage.
        wv = 1'b1;
        fdata = 32'h0000_DEAD;
        tick();
        wv = 1'b0;
        tick();
        do_read(24'h000108, 32'h0, 0, -1, 1'b0, got);
        chk("stray_beat_hit", got, 32'hA2);

        // Conflict on index 16: 0x300 evicts 0x100, then 0x100 misses again.
        do_read(24'h000300, 32'hB0, 1, -1, 1'b0, got);
        chk("conflict_fill", got, 32'hB0);
        do_read(24'h000100, 32'hA0, 0, -1, 1'b0, got);
        chk("conflict_refill", got, 32'hA0);

        // Invalidate mid-fill: response still right, line left invalid.
        do_read(24'h000204, 32'hC0, 0, 1, 1'b0, got);
        chk("inv_fill_data", got, 32'hC1);
        chk("inv_model_line", {31'd0, m_valid[0]}, 32'd0);
        do_read(24'h000200, 32'hC0, 0, -1, 1'b0, got);
        chk("after_inv_miss", got, 32'hC0);

        // Invalidate coincident with the request forces a miss.
        do_read(24'h000208, 32'hD0, 0, -1, 1'b1, got);
        chk("inv_start_miss", got, 32'hD2);

        // Reset after two fill words.
        addr = 24'h000500;
        re = 1'b1;
        tick();
        tick();
        exp_req = 1'b1;
        exp_faddr = 24'h000500;
        for (int w = 0; w < 2; w++) begin
            wv = 1'b1;
            fdata = 32'hE0 + 32'(w);
            tick();
            wv = 1'b0;
        end
        rst_n = 1'b0;
        re = 1'b0;
        idle_exp();
        clear_model();
        #1;
        chk("rst_request", {31'd0, freq}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_data", rdata, 32'hFFFF_FFFF);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Same line misses after reset; then back-to-back hit.
        do_read(24'h000504, 32'hE0, 0, -1, 1'b0, got);
        chk("post_rst_miss", got, 32'hE1);
        do_read(24'h00050C, 32'h0, 0, -1, 1'b0, got);
        chk("b2b_hit", got, 32'hE3);
        do_read(24'h000200, 32'hF0, 0, -1, 1'b0, got);
        chk("post_rst_other_miss", got, 32'hF0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
